// File: rtl/ucsbece154b_result_checker.sv
// Harness controller for processor simulation: sequences core reset, runs the core
// for a bounded budget or until halt, then walks a masked check table and reports.
module ucsbece154b_result_checker #(
  parameter int WIDTH        = 32,
  parameter int NUM_CHECKS   = 16,
  parameter int IDX_W        = 4,
  parameter int RESET_CYCLES = 2,
  parameter int RUN_CYCLES   = 100,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             halt_i,
  input  logic [WIDTH-1:0] chk_actual_i,
  input  logic [WIDTH-1:0] chk_expected_i,
  input  logic [WIDTH-1:0] chk_mask_i,
  input  logic             chk_valid_i,
  output logic             core_reset_o,
  output logic             freeze_o,
  output logic [IDX_W-1:0] chk_idx_o,
  output logic [CNT_W-1:0] cycle_count_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [IDX_W:0]   fail_count_o,
  output logic [IDX_W-1:0] first_fail_idx_o,
  output logic             first_fail_valid_o
);

  typedef enum logic [1:0] {HOLD, RUN, CHECK, DONE} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST  = CNT_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_CHECKS - 1);

  state_t           state;
  logic [CNT_W-1:0] hold_cnt;
  logic             entry_fail;
  logic [IDX_W:0]   fail_count_next;

  // Disabled entries never fail; unmasked bits are don't-care.
  always_comb begin
    entry_fail      = chk_valid_i & (|((chk_actual_i ^ chk_expected_i) & chk_mask_i));
    fail_count_next = fail_count_o + {{IDX_W{1'b0}}, entry_fail};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= HOLD;
      hold_cnt           <= '0;
      core_reset_o       <= 1'b1;
      freeze_o           <= 1'b0;
      chk_idx_o          <= '0;
      cycle_count_o      <= '0;
      busy_o             <= 1'b1;
      done_o             <= 1'b0;
      pass_o             <= 1'b0;
      fail_count_o       <= '0;
      first_fail_idx_o   <= '0;
      first_fail_valid_o <= 1'b0;
    end else begin
      case (state)
        HOLD: begin
          hold_cnt <= hold_cnt + 1'b1;
          if (hold_cnt == HOLD_LAST) begin
            state        <= RUN;
            core_reset_o <= 1'b0;
          end
        end
        RUN: begin
          cycle_count_o <= cycle_count_o + 1'b1;
          if (halt_i || (cycle_count_o == RUN_LAST)) begin
            state    <= CHECK;
            freeze_o <= 1'b1;
          end
        end
        CHECK: begin
          fail_count_o <= fail_count_next;
          if (entry_fail && !first_fail_valid_o) begin
            first_fail_idx_o   <= chk_idx_o;
            first_fail_valid_o <= 1'b1;
          end
          // pass_o uses the next count so the last entry's verdict is included.
          if (chk_idx_o == IDX_LAST) begin
            state     <= DONE;
            chk_idx_o <= '0;
            busy_o    <= 1'b0;
            done_o    <= 1'b1;
            pass_o    <= (fail_count_next == '0);
          end else begin
            chk_idx_o <= chk_idx_o + 1'b1;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule
